i2c_tx_scheduler: RTL

// Shares one i2c_transmitter between NUM_REQ requesters using round-robin arbitration.

---
 rtl/i2c_tx_scheduler_pkg.sv | 17 +
 rtl/i2c_tx_scheduler_rr_arbiter.sv | 33 +++
 rtl/i2c_tx_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/i2c_tx_scheduler_pkg.sv
// Shared constants and the scheduler state type for the I2C transmit scheduler.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W       = 7;
    localparam int unsigned I2C_DATA_W       = 8;
    // Nominal length of one transmitter frame in clock cycles; the timeout must exceed it.
    localparam int unsigned I2C_FRAME_CYCLES = 62;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_BUSY   = 3'd2,
        ST_ABORT  = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

endpackage

// File: rtl/i2c_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from last+1 with wrap.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Rotating priority search; the first hit after the previous winner takes the grant.
    always_comb begin
        int unsigned k;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            k = 32'(last) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!valid && req[IDX_W'(k)]) begin
                valid               = 1'b1;
                grant[IDX_W'(k)]    = 1'b1;
                idx                 = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/i2c_tx_scheduler.sv
// Shares one I2C transmitter between several requesters with round-robin arbitration,
// a hung-transaction timeout that resets the transmitter, and an inter-frame gap.
module i2c_tx_scheduler
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned GAP_CYCLES     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic                          ack_ok,
    output logic                          busy,
    output logic                          tx_start,
    output logic [I2C_ADDR_W-1:0]         tx_address,
    output logic [I2C_DATA_W-1:0]         tx_data,
    output logic                          tx_rstn,
    input  logic                          tx_finished,
    input  logic                          tx_ack
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        last, last_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [GAP_W-1:0]        gap_cnt, gap_n;
    logic [NUM_REQ-1:0]      grant_n, done_n, err_n;
    logic                    ack_n, start_n, rstn_n;
    logic [I2C_ADDR_W-1:0]   addr_n;
    logic [I2C_DATA_W-1:0]   data_n;

    logic [NUM_REQ-1:0]      arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_valid;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .last  (last),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign busy = (state != ST_IDLE);

    // State register plus registered outputs; reset holds the transmitter in reset too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last       <= IDX_W'(NUM_REQ - 1);
            cnt        <= '0;
            gap_cnt    <= '0;
            grant      <= '0;
            done       <= '0;
            err        <= '0;
            ack_ok     <= 1'b0;
            tx_start   <= 1'b0;
            tx_rstn    <= 1'b0;
            tx_address <= '0;
            tx_data    <= '0;
        end else begin
            state      <= state_n;
            last       <= last_n;
            cnt        <= cnt_n;
            gap_cnt    <= gap_n;
            grant      <= grant_n;
            done       <= done_n;
            err        <= err_n;
            ack_ok     <= ack_n;
            tx_start   <= start_n;
            tx_rstn    <= rstn_n;
            tx_address <= addr_n;
            tx_data    <= data_n;
        end
    end

    // Next-state and next-output logic. Pulses (done/err/tx_rstn low) are computed on the
    // transition so they appear in the cycle after the deciding edge, aligned with ABORT/GAP.
    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        gap_n   = gap_cnt;
        grant_n = grant;
        done_n  = '0;
        err_n   = '0;
        ack_n   = 1'b0;
        start_n = 1'b0;
        rstn_n  = 1'b1;
        addr_n  = tx_address;
        data_n  = tx_data;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_n = ST_LAUNCH;
                    grant_n = arb_grant;
                    last_n  = arb_idx;
                    addr_n  = req_addr[arb_idx*I2C_ADDR_W +: I2C_ADDR_W];
                    data_n  = req_data[arb_idx*I2C_DATA_W +: I2C_DATA_W];
                end
            end
            ST_LAUNCH: begin
                start_n = 1'b1;
                cnt_n   = '0;
                state_n = ST_BUSY;
            end
            ST_BUSY: begin
                if (tx_finished) begin
                    done_n  = grant;
                    ack_n   = tx_ack;
                    grant_n = '0;
                    gap_n   = '0;
                    state_n = ST_GAP;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_n   = grant;
                    rstn_n  = 1'b0;
                    state_n = ST_ABORT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_ABORT: begin
                grant_n = '0;
                gap_n   = '0;
                state_n = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
